// File: rtl/dmem_responder.sv
// Data-memory responder: byte-addressed RAM behind the core load/store port, zeroed after reset.
// Latency: load data/valid one cycle after the request edge; stores visible to the next load.
// Backpressure: none; requests arriving while busy (clearing) are silently dropped.
module dmem_responder #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              access_err,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int WIDX_W = ADDR_W - 2;
    localparam int WORDS  = 1 << WIDX_W;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [2:0]        funct3;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wr_dat;
    } req_t;

    logic [DATA_W-1:0] mem [WORDS];

    state_t            state;
    state_t            state_nxt;
    logic [WIDX_W-1:0] clr_idx;

    req_t              req;
    logic              acc_vld;
    logic [1:0]        size;
    logic              aligned;
    logic              ld_legal;
    logic              st_legal;
    logic              ld_ok;
    logic              st_ok;
    logic              err_hit;
    logic [WIDX_W-1:0] widx;
    logic [DATA_W-1:0] word_rd;
    logic [DATA_W-1:0] word_sh;
    logic [DATA_W-1:0] ld_ext;
    logic [3:0]        st_be;
    logic [DATA_W-1:0] st_dat;

    always_comb begin
        req.rd     = rd;
        req.wr     = wr;
        req.funct3 = funct3;
        req.addr   = addr;
        req.wr_dat = wr_data;
    end

    // ---------------- clear sequencer FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (clr_idx == WIDX_W'(WORDS - 1)) state_nxt = ST_READY;
            ST_READY: state_nxt = ST_READY;
            default:  state_nxt = ST_CLEAR;
        endcase
    end

    always_comb begin
        busy = (state == ST_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clr_idx <= '0;
        end else if (state == ST_CLEAR) begin
            clr_idx <= clr_idx + 1'b1;
        end
    end

    // ---------------- request decode ----------------
    always_comb begin
        acc_vld = (state == ST_READY) && !reset;
        size    = req.funct3[1:0];
        case (size)
            2'd0:    aligned = 1'b1;
            2'd1:    aligned = !req.addr[0];
            2'd2:    aligned = (req.addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        ld_legal = aligned && (req.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        st_legal = aligned && !req.funct3[2];
        ld_ok    = acc_vld && req.rd && ld_legal;
        st_ok    = acc_vld && req.wr && st_legal;
        err_hit  = acc_vld && ((req.rd && !ld_legal) || (req.wr && !st_legal));
        widx     = req.addr[ADDR_W-1:2];
    end

    // Load path reads the old word, so a same-cycle store is not visible (read-before-write).
    always_comb begin
        word_rd = mem[widx];
        word_sh = word_rd >> {req.addr[1:0], 3'b000};
        case (req.funct3)
            3'b000:  ld_ext = {{(DATA_W-8){word_sh[7]}}, word_sh[7:0]};
            3'b001:  ld_ext = {{(DATA_W-16){word_sh[15]}}, word_sh[15:0]};
            3'b100:  ld_ext = {{(DATA_W-8){1'b0}}, word_sh[7:0]};
            3'b101:  ld_ext = {{(DATA_W-16){1'b0}}, word_sh[15:0]};
            default: ld_ext = word_rd;
        endcase
    end

    always_comb begin
        st_dat = req.wr_dat << {req.addr[1:0], 3'b000};
        case (size)
            2'd0:    st_be = 4'b0001 << req.addr[1:0];
            2'd1:    st_be = 4'b0011 << req.addr[1:0];
            default: st_be = 4'b1111;
        endcase
    end

    // ---------------- storage ----------------
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_idx] <= '0;
        end else if (st_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) mem[widx][8*b +: 8] <= st_dat[8*b +: 8];
            end
        end
    end

    // ---------------- response, status and counters ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= acc_vld && req.rd;
            if (acc_vld && req.rd) begin
                rd_data <= ld_legal ? ld_ext : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            access_err <= 1'b0;
            rd_count   <= '0;
            wr_count   <= '0;
        end else begin
            if (err_hit) access_err <= 1'b1;
            if (ld_ok)   rd_count   <= rd_count + 1'b1;
            if (st_ok)   wr_count   <= wr_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-array reference model checked every cycle, plus directed literal cases.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd;
    logic        wr;
    logic [8:0]  addr;
    logic [31:0] wr_data;
    logic [2:0]  funct3;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        access_err;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    int n_chk  = 0;
    int n_fail = 0;

    dmem_responder #(.DATA_W(32), .ADDR_W(9), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .rd         (rd),
        .wr         (wr),
        .addr       (addr),
        .wr_data    (wr_data),
        .funct3     (funct3),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .busy       (busy),
        .access_err (access_err),
        .rd_count   (rd_count),
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail < 40) $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  m_mem [512];
    int          m_left = 0;
    logic        m_vld, m_err;
    logic [31:0] m_dat;
    logic [15:0] m_rc, m_wc;
    bit          chk_en = 0;

    always @(posedge clk) begin
        int nb;
        bit al, ldl, stl;
        logic [31:0] v;
        if (reset) begin
            chk_en = 1;
            m_left = 128;
            m_vld = 0; m_dat = 0; m_err = 0; m_rc = 0; m_wc = 0;
            for (int i = 0; i < 512; i++) m_mem[i] = 8'h00;
        end else if (m_left > 0) begin
            m_left--;
            m_vld = 0;
        end else begin
            nb  = 1 << funct3[1:0];
            al  = (funct3[1:0] != 2'd3) && ((int'(addr) % nb) == 0);
            ldl = al && !(funct3 inside {3'd3, 3'd6, 3'd7});
            stl = al && (funct3 <= 3'd2);
            m_vld = rd;
            if (rd) begin
                if (ldl) begin
                    v = 0;
                    for (int i = 0; i < nb; i++) v = v | (32'(m_mem[int'(addr) + i]) << (8 * i));
                    if (!funct3[2] && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
                    m_dat = v;
                    m_rc++;
                end else begin
                    m_dat = 0;
                    m_err = 1;
                end
            end
            if (wr) begin
                if (stl) begin
                    for (int i = 0; i < nb; i++) m_mem[int'(addr) + i] = wr_data[8*i +: 8];
                    m_wc++;
                end else begin
                    m_err = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",       32'(busy),       32'(m_left > 0));
            chk("rd_valid",   32'(rd_valid),   32'(m_vld));
            chk("rd_data",    rd_data,         m_dat);
            chk("access_err", 32'(access_err), 32'(m_err));
            chk("rd_count",   32'(rd_count),   32'(m_rc));
            chk("wr_count",   32'(wr_count),   32'(m_wc));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic r, input logic w, input logic [2:0] f3,
                       input logic [8:0] a, input logic [31:0] d);
        rd = r; wr = w; funct3 = f3; addr = a; wr_data = d;
        @(posedge clk); #1;
        rd = 0; wr = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
    endtask

    task automatic wait_clear(input string nm);
        int n = 0;
        while (busy && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk(nm, n, 128);
    endtask

    task automatic ld(input string nm, input logic [2:0] f3, input logic [8:0] a,
                      input logic [31:0] exp);
        cyc(1, 0, f3, a, 0);
        chk({nm, "_vld"}, 32'(rd_valid), 1);
        chk(nm, rd_data, exp);
    endtask

    initial begin
        logic [15:0] rc0, wc0;
        reset = 1; rd = 0; wr = 0; funct3 = 0; addr = 0; wr_data = 0;
        @(posedge clk); #1;
        do_reset();
        chk("rst_busy", 32'(busy), 1);
        chk("rst_vld",  32'(rd_valid), 0);
        chk("rst_data", rd_data, 0);
        chk("rst_err",  32'(access_err), 0);
        chk("rst_rc",   32'(rd_count), 0);
        wait_clear("clear_len");

        ld("lw_000", 3'b010, 9'h000, 32'h0);
        ld("lw_1fc", 3'b010, 9'h1FC, 32'h0);
        ld("lw_0a4", 3'b010, 9'h0A4, 32'h0);
        chk("rc_3", 32'(rd_count), 3);

        cyc(0, 1, 3'b010, 9'h010, 32'h80F0_7F01);
        ld("lb_010",  3'b000, 9'h010, 32'h0000_0001);
        ld("lb_013",  3'b000, 9'h013, 32'hFFFF_FF80);
        ld("lbu_013", 3'b100, 9'h013, 32'h0000_0080);
        ld("lh_012",  3'b001, 9'h012, 32'hFFFF_80F0);
        ld("lhu_012", 3'b101, 9'h012, 32'h0000_80F0);

        cyc(0, 1, 3'b010, 9'h020, 32'hFFFF_FFFF);
        cyc(0, 1, 3'b000, 9'h021, 32'h0000_005A);
        cyc(0, 1, 3'b001, 9'h022, 32'h0000_1234);
        ld("lw_020", 3'b010, 9'h020, 32'h1234_5AFF);

        cyc(0, 1, 3'b010, 9'h040, 32'h1111_1111);
        rc0 = rd_count; wc0 = wr_count;
        cyc(1, 1, 3'b010, 9'h040, 32'hDEAD_BEEF);
        chk("rbw_data", rd_data, 32'h1111_1111);
        chk("rbw_rc", 32'(rd_count), 32'(rc0 + 16'd1));
        chk("rbw_wc", 32'(wr_count), 32'(wc0 + 16'd1));
        ld("lw_040", 3'b010, 9'h040, 32'hDEAD_BEEF);

        rc0 = rd_count;
        ld("lw_041", 3'b010, 9'h041, 32'h0);
        chk("err_set", 32'(access_err), 1);
        chk("err_rc",  32'(rd_count), 32'(rc0));
        cyc(0, 1, 3'b001, 9'h043, 32'h0000_ABCD);
        ld("lw_040b", 3'b010, 9'h040, 32'hDEAD_BEEF);
        chk("err_sticky", 32'(access_err), 1);

        // Random traffic, mostly concentrated on a small window to get read-after-write hits.
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] f3;
            logic [8:0] a;
            f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 7));
            if (f3 == 3'd3 && $urandom_range(0, 1) == 0) f3 = 3'd2;
            a  = ($urandom_range(0, 3) != 0) ? 9'($urandom_range(0, 63)) : 9'($urandom_range(0, 511));
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'd1) a[0] = 1'b0;
                if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
            end
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), f3, a, $urandom);
        end

        do_reset();
        wait_clear("clear_len2");
        for (int i = 0; i < 65535; i++) cyc(0, 1, 3'b000, 9'(i), 32'(i));
        chk("wc_ffff", 32'(wr_count), 32'h0000_FFFF);
        cyc(0, 1, 3'b000, 9'h005, 32'h0000_0077);
        chk("wc_wrap", 32'(wr_count), 0);

        do_reset();
        repeat (50) begin @(posedge clk); #1; end
        do_reset();
        wait_clear("clear_restart");
        chk("rst2_rc",  32'(rd_count), 0);
        chk("rst2_wc",  32'(wr_count), 0);
        chk("rst2_err", 32'(access_err), 0);
        ld("lw_005_zero", 3'b010, 9'h004, 32'h0);

        @(posedge clk); #1;
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
